spram_arbiter: RTL and testbench
================================

Name: spram_arbiter

Overview:
- Two-requester access arbiter for one single-port RAM (en/we/addr/din, registered dout, 1-cycle read latency) used as a line buffer in the sliding-window filters.
- Typical clients: the line-buffer write side (port A) and the window-fetch/readback side (port B).
- Issues one RAM access per cycle.
- Round-robin or fixed priority, with a starvation guard in fixed mode.
- Returns read data to the granted requester with a valid strobe.

Parameters:
ADDR_BITS, 7, RAM address width
DATA_BITS, 32, RAM data width
PRIO_MODE, 0, 0 = round robin; 1 = fixed priority to A
MAX_WAIT, 8, fixed mode only: consecutive lost contentions after which B is forced to win; range 1..255

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
a_req  in  1  port A access request, held until granted
a_we  in  1  port A write (1) / read (0)
a_addr  in  ADDR_BITS  port A address
a_din  in  DATA_BITS  port A write data
a_gnt  out  1  port A request accepted this cycle
a_rvalid  out  1  port A read data valid
a_rdata  out  DATA_BITS  port A read data
b_req, b_we, b_addr, b_din, b_gnt, b_rvalid, b_rdata  same as port A, for port B
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_BITS  RAM address
ram_din  out  DATA_BITS  RAM write data
ram_dout  in  DATA_BITS  RAM registered read data

Behaviour:
- Reset (asynchronous): a_rvalid = b_rvalid = 0; last_grant = B (so A wins the first contention); wait_cnt = 0.
- During reset: a_gnt = b_gnt = ram_en = ram_we = 0. ram_addr and ram_din are don't-care, driven 0.
- Grant is combinational in cycle t:
  - only A requests: a_gnt = 1.
  - only B requests: b_gnt = 1.
  - neither requests: no grant, ram_en = 0.
  - at most one gnt is high in any cycle.
- Contention, PRIO_MODE 0: grant the port that is not last_grant. last_grant updates on every grant.
- Contention, PRIO_MODE 1: A wins unless wait_cnt == MAX_WAIT, in which case B wins.
  - wait_cnt increments when B requests and loses.
  - wait_cnt clears when B is granted or B deasserts its request.
  - wait_cnt saturates at MAX_WAIT.
- RAM mux: when a port is granted, ram_en = 1 and ram_we/ram_addr/ram_din are that port's we/addr/din, in the same cycle.
- Read return: a granted read in cycle t gives x_rvalid = 1 for exactly cycle t+1, with x_rdata = ram_dout.
- Granted writes produce no rvalid.
- x_rdata carries ram_dout on both ports at all times; it is meaningful only when x_rvalid = 1.
- Back-to-back: one access per cycle sustained. A read granted at t and a read for the other port granted at t+1 give rvalids at t+1 and t+2 on their respective ports.
- Requester contract:
  - req, we, addr and din stay stable while req = 1 and gnt = 0.
  - req may deassert in the cycle after gnt, or stay high to issue a new access.
  - The arbiter does not check this contract.
- Same-address write then read by different ports in consecutive cycles: the read returns the new data.
- Reset mid-operation: a pending rvalid from the cycle before reset is dropped; no rvalid is seen after reset deasserts until a new read is granted.
- Throughput under continuous contention:
  - PRIO_MODE 0: strict alternation A, B, A, B.
  - PRIO_MODE 1: A × MAX_WAIT, then B × 1, repeating.
- No X propagation to ram_en/ram_we when req inputs are 0.

Test Plan:
- Reset, then A write addr 5 = 0xDEADBEEF (b_req = 0), then A read addr 5 -> a_gnt = 1 each cycle; a_rvalid = 1 one cycle after the read grant with a_rdata = 0xDEADBEEF; b_rvalid stays 0.
- PRIO_MODE 0: A and B both continuously request reads of addr 1 and addr 2 for 6 cycles -> grants A, B, A, B, A, B; rvalids alternate a/b one cycle later with the correct data per port.
- PRIO_MODE 1, MAX_WAIT = 3: both request continuously for 8 cycles -> grants A, A, A, B, A, A, A, B; wait_cnt returns to 0 after each B grant.
- Cross-port coherency: A writes addr 10 = 0x12345678 at cycle t, B reads addr 10 at t+1 -> b_rvalid at t+2 with b_rdata = 0x12345678.
- A read granted at cycle t, rst pulsed high asynchronously mid-cycle t+1 -> a_rvalid = 0 immediately; all gnt/ram_en = 0 during reset; first contention after reset grants A.
- Idle: both req = 0 for 10 cycles -> ram_en = 0, no gnt, no rvalid; the round-robin pointer does not change.

Source files
------------

// File: rtl/spram_arbiter.sv
// Two-port arbiter in front of one single-port RAM: combinational grant, read data valid one cycle after grant.
// Backpressure: a requester holds req/we/addr/din until its gnt; round robin or fixed priority with starvation guard.
module spram_arbiter #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 32,
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [DATA_BITS-1:0] a_din,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [DATA_BITS-1:0] a_rdata,

    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [DATA_BITS-1:0] b_din,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [DATA_BITS-1:0] b_rdata,

    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_din,
    input  logic [DATA_BITS-1:0] ram_dout
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    port_t      last_grant;
    logic [7:0] wait_cnt;
    logic       a_rd_pend;
    logic       b_rd_pend;
    logic       contention;
    logic       b_wins;

    // Grant decision; forced low while reset is asserted so the RAM sees no access.
    always_comb begin
        contention = a_req & b_req;
        if (PRIO_MODE == 0) begin
            b_wins = (last_grant == PORT_A);
        end else begin
            b_wins = (wait_cnt == WAIT_LIMIT);
        end

        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (contention) begin
                a_gnt = ~b_wins;
                b_gnt = b_wins;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        ram_en   = a_gnt | b_gnt;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (a_gnt) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_din  = a_din;
        end else if (b_gnt) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_din  = b_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_B;
            wait_cnt   <= '0;
            a_rd_pend  <= 1'b0;
            b_rd_pend  <= 1'b0;
        end else begin
            if (a_gnt) begin
                last_grant <= PORT_A;
            end else if (b_gnt) begin
                last_grant <= PORT_B;
            end

            // Counts consecutive contentions B has lost; saturates at the limit.
            if (!b_req || b_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            a_rd_pend <= a_gnt & ~a_we;
            b_rd_pend <= b_gnt & ~b_we;
        end
    end

    assign a_rvalid = a_rd_pend;
    assign b_rvalid = b_rd_pend;
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench: dut0 runs round robin, dut1 runs fixed priority with MAX_WAIT = 3; both share stimulus.
module tb_spram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [6:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_din = '0, b_din = '0;

    logic        a_gnt0, b_gnt0, a_rv0, b_rv0, ram_en0, ram_we0;
    logic [31:0] a_rd0, b_rd0, ram_din0, dout0;
    logic [6:0]  ram_addr0;
    logic        a_gnt1, b_gnt1, a_rv1, b_rv1, ram_en1, ram_we1;
    logic [31:0] a_rd1, b_rd1, ram_din1, dout1;
    logic [6:0]  ram_addr1;

    logic [31:0] mem0 [0:127];
    logic [31:0] mem1 [0:127];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spram_arbiter #(.ADDR_BITS(7), .DATA_BITS(32), .PRIO_MODE(0), .MAX_WAIT(8)) dut0 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_gnt(a_gnt0), .a_rvalid(a_rv0), .a_rdata(a_rd0),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_gnt(b_gnt0), .b_rvalid(b_rv0), .b_rdata(b_rd0),
        .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_din(ram_din0),
        .ram_dout(dout0)
    );

    spram_arbiter #(.ADDR_BITS(7), .DATA_BITS(32), .PRIO_MODE(1), .MAX_WAIT(3)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_gnt(a_gnt1), .a_rvalid(a_rv1), .a_rdata(a_rd1),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_gnt(b_gnt1), .b_rvalid(b_rv1), .b_rdata(b_rd1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1),
        .ram_dout(dout1)
    );

    // Single-port RAMs with registered read data.
    always @(posedge clk) begin
        if (ram_en0) begin
            if (ram_we0) mem0[ram_addr0] <= ram_din0;
            else         dout0 <= mem0[ram_addr0];
        end
        if (ram_en1) begin
            if (ram_we1) mem1[ram_addr1] <= ram_din1;
            else         dout1 <= mem1[ram_addr1];
        end
    end

    task automatic drv(input logic ar, input logic aw, input logic [6:0] aa, input logic [31:0] ad,
                       input logic br, input logic bw, input logic [6:0] ba, input logic [31:0] bd);
        @(posedge clk);
        #1;
        a_req = ar; a_we = aw; a_addr = aa; a_din = ad;
        b_req = br; b_we = bw; b_addr = ba; b_din = bd;
        @(negedge clk);
    endtask

    task automatic test_reset;
        a_req = 1'b1; b_req = 1'b1;
        #3;
        n_tests++; if ({a_gnt0, b_gnt0, ram_en0, ram_we0} !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt0 got %b exp 0000", {a_gnt0, b_gnt0, ram_en0, ram_we0}); end
        n_tests++; if ({a_gnt1, b_gnt1, ram_en1, ram_we1} !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt1 got %b exp 0000", {a_gnt1, b_gnt1, ram_en1, ram_we1}); end
        n_tests++; if ({a_rv0, b_rv0, a_rv1, b_rv1} !== 4'b0000) begin n_fail++; $display("FAIL rst_rvalid got %b exp 0000", {a_rv0, b_rv0, a_rv1, b_rv1}); end
        n_tests++; if ({ram_addr0, ram_din0} !== 39'd0) begin n_fail++; $display("FAIL rst_ram_bus got %h exp 0", {ram_addr0, ram_din0}); end
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single_port;
        drv(1, 1, 7'd5, 32'hDEADBEEF, 0, 0, 7'd0, 32'd0);
        n_tests++; if ({a_gnt0, b_gnt0, ram_en0, ram_we0} !== 4'b1011) begin n_fail++; $display("FAIL sp_wr_ctl got %b exp 1011", {a_gnt0, b_gnt0, ram_en0, ram_we0}); end
        n_tests++; if (ram_addr0 !== 7'd5 || ram_din0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sp_wr_bus got %h/%h exp 05/deadbeef", ram_addr0, ram_din0); end
        drv(1, 0, 7'd5, 32'd0, 0, 0, 7'd0, 32'd0);
        n_tests++; if ({a_gnt0, ram_en0, ram_we0, a_rv0} !== 4'b1100) begin n_fail++; $display("FAIL sp_rd_ctl got %b exp 1100", {a_gnt0, ram_en0, ram_we0, a_rv0}); end
        drv(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
        n_tests++; if (a_rv0 !== 1'b1 || a_rd0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sp_rdata got %b/%h exp 1/deadbeef", a_rv0, a_rd0); end
        n_tests++; if (b_rv0 !== 1'b0 || ram_en0 !== 1'b0) begin n_fail++; $display("FAIL sp_b_quiet got %b%b exp 00", b_rv0, ram_en0); end
        drv(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
        n_tests++; if (a_rv0 !== 1'b0) begin n_fail++; $display("FAIL sp_rvalid_once got %b exp 0", a_rv0); end
    endtask

    task automatic test_round_robin;
        logic exp_a, prev_a;
        drv(1, 1, 7'd1, 32'h11111111, 0, 0, 7'd0, 32'd0);
        drv(0, 0, 7'd0, 32'd0, 1, 1, 7'd2, 32'h22222222);
        n_tests++; if (b_gnt0 !== 1'b1 || ram_addr0 !== 7'd2) begin n_fail++; $display("FAIL rr_b_write got %b/%h exp 1/02", b_gnt0, ram_addr0); end
        for (int i = 0; i < 6; i++) begin
            drv(1, 0, 7'd1, 32'd0, 1, 0, 7'd2, 32'd0);
            exp_a = (i % 2 == 0);
            n_tests++; if ({a_gnt0, b_gnt0} !== {exp_a, ~exp_a}) begin n_fail++; $display("FAIL rr_grant[%0d] got %b%b exp %b%b", i, a_gnt0, b_gnt0, exp_a, ~exp_a); end
            if (i > 0) begin
                prev_a = ((i - 1) % 2 == 0);
                n_tests++; if ({a_rv0, b_rv0} !== {prev_a, ~prev_a}) begin n_fail++; $display("FAIL rr_rvalid[%0d] got %b%b exp %b%b", i, a_rv0, b_rv0, prev_a, ~prev_a); end
                n_tests++; if ((prev_a ? a_rd0 : b_rd0) !== (prev_a ? 32'h11111111 : 32'h22222222)) begin n_fail++; $display("FAIL rr_rdata[%0d] got %h/%h", i, a_rd0, b_rd0); end
            end
        end
        drv(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
        n_tests++; if ({a_rv0, b_rv0} !== 2'b01 || b_rd0 !== 32'h22222222) begin n_fail++; $display("FAIL rr_last_rvalid got %b%b/%h exp 01/22222222", a_rv0, b_rv0, b_rd0); end
    endtask

    task automatic test_fixed_priority;
        logic exp_b, prev_b;
        for (int i = 0; i < 8; i++) begin
            drv(1, 0, 7'd1, 32'd0, 1, 0, 7'd2, 32'd0);
            exp_b = (i % 4 == 3);
            n_tests++; if ({a_gnt1, b_gnt1} !== {~exp_b, exp_b}) begin n_fail++; $display("FAIL fx_grant[%0d] got %b%b exp %b%b", i, a_gnt1, b_gnt1, ~exp_b, exp_b); end
            if (i > 0) begin
                prev_b = ((i - 1) % 4 == 3);
                n_tests++; if ({a_rv1, b_rv1} !== {~prev_b, prev_b}) begin n_fail++; $display("FAIL fx_rvalid[%0d] got %b%b exp %b%b", i, a_rv1, b_rv1, ~prev_b, prev_b); end
                n_tests++; if ((prev_b ? b_rd1 : a_rd1) !== (prev_b ? 32'h22222222 : 32'h11111111)) begin n_fail++; $display("FAIL fx_rdata[%0d] got %h/%h", i, a_rd1, b_rd1); end
            end
        end
        drv(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
        n_tests++; if ({a_rv1, b_rv1} !== 2'b01) begin n_fail++; $display("FAIL fx_last_rvalid got %b%b exp 01", a_rv1, b_rv1); end
    endtask

    task automatic test_coherency;
        drv(1, 1, 7'd10, 32'h12345678, 0, 0, 7'd0, 32'd0);
        n_tests++; if (a_gnt1 !== 1'b1 || ram_we1 !== 1'b1) begin n_fail++; $display("FAIL coh_wr got %b%b exp 11", a_gnt1, ram_we1); end
        drv(0, 0, 7'd0, 32'd0, 1, 0, 7'd10, 32'd0);
        n_tests++; if (b_gnt1 !== 1'b1 || ram_addr1 !== 7'd10 || ram_we1 !== 1'b0) begin n_fail++; $display("FAIL coh_rd got %b/%h/%b exp 1/0a/0", b_gnt1, ram_addr1, ram_we1); end
        drv(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
        n_tests++; if (b_rv1 !== 1'b1 || b_rd1 !== 32'h12345678) begin n_fail++; $display("FAIL coh_data1 got %b/%h exp 1/12345678", b_rv1, b_rd1); end
        n_tests++; if (b_rv0 !== 1'b1 || b_rd0 !== 32'h12345678) begin n_fail++; $display("FAIL coh_data0 got %b/%h exp 1/12345678", b_rv0, b_rd0); end
    endtask

    task automatic test_reset_mid;
        drv(1, 0, 7'd5, 32'd0, 0, 0, 7'd0, 32'd0);
        n_tests++; if (a_gnt0 !== 1'b1) begin n_fail++; $display("FAIL rm_read_gnt got %b exp 1", a_gnt0); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_tests++; if ({a_rv0, a_rv1} !== 2'b00) begin n_fail++; $display("FAIL rm_rvalid_drop got %b exp 00", {a_rv0, a_rv1}); end
        n_tests++; if ({a_gnt0, a_gnt1, ram_en0, ram_en1} !== 4'b0000) begin n_fail++; $display("FAIL rm_gnt_in_rst got %b exp 0000", {a_gnt0, a_gnt1, ram_en0, ram_en1}); end
        a_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drv(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
        n_tests++; if ({a_rv0, b_rv0, a_rv1, b_rv1} !== 4'b0000) begin n_fail++; $display("FAIL rm_no_rvalid got %b exp 0000", {a_rv0, b_rv0, a_rv1, b_rv1}); end
        drv(1, 1, 7'd20, 32'hAAAA0000, 1, 1, 7'd21, 32'hBBBB0000);
        n_tests++; if ({a_gnt0, b_gnt0} !== 2'b10) begin n_fail++; $display("FAIL rm_first_contention0 got %b%b exp 10", a_gnt0, b_gnt0); end
        n_tests++; if ({a_gnt1, b_gnt1} !== 2'b10) begin n_fail++; $display("FAIL rm_first_contention1 got %b%b exp 10", a_gnt1, b_gnt1); end
        drv(0, 0, 7'd0, 32'd0, 1, 1, 7'd21, 32'hBBBB0000);
        n_tests++; if (b_gnt0 !== 1'b1 || ram_din0 !== 32'hBBBB0000) begin n_fail++; $display("FAIL rm_b_write got %b/%h exp 1/bbbb0000", b_gnt0, ram_din0); end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 10; i++) begin
            drv(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
            n_tests++; if ({ram_en0, ram_we0, a_gnt0, b_gnt0, a_rv0, b_rv0} !== 6'b000000) begin n_fail++; $display("FAIL idle0[%0d] got %b exp 000000", i, {ram_en0, ram_we0, a_gnt0, b_gnt0, a_rv0, b_rv0}); end
            n_tests++; if ({ram_en1, ram_we1, a_gnt1, b_gnt1, a_rv1, b_rv1} !== 6'b000000) begin n_fail++; $display("FAIL idle1[%0d] got %b exp 000000", i, {ram_en1, ram_we1, a_gnt1, b_gnt1, a_rv1, b_rv1}); end
        end
        drv(1, 0, 7'd1, 32'd0, 1, 0, 7'd2, 32'd0);
        n_tests++; if ({a_gnt0, b_gnt0} !== 2'b10) begin n_fail++; $display("FAIL idle_ptr_a got %b%b exp 10", a_gnt0, b_gnt0); end
        drv(1, 0, 7'd1, 32'd0, 1, 0, 7'd2, 32'd0);
        n_tests++; if ({a_gnt0, b_gnt0} !== 2'b01 || a_rv0 !== 1'b1 || a_rd0 !== 32'h11111111) begin n_fail++; $display("FAIL idle_ptr_b got %b%b/%b/%h exp 01/1/11111111", a_gnt0, b_gnt0, a_rv0, a_rd0); end
        drv(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
        n_tests++; if (b_rv0 !== 1'b1 || b_rd0 !== 32'h22222222) begin n_fail++; $display("FAIL idle_tail got %b/%h exp 1/22222222", b_rv0, b_rd0); end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_fixed_priority();
        test_coherency();
        test_reset_mid();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
